mem_access_stage: RTL and testbench

//  MEM stage directly downstream of the EX/ALU stage. Takes the ALU result pair,

---
 rtl/mips_pkg.sv | 23 ++
 rtl/mem_req_fsm.sv | 81 ++++++++
 rtl/mem_access_stage.sv | 127 ++++++++++++
 tb/tb_mem_access_stage.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: memory opcodes, control byte layout and
// the MEM-stage request FSM state type.
package mips_pkg;

   // Opcodes that go through the data-memory port.
   localparam logic [5:0] OP_LW = 6'b100011;
   localparam logic [5:0] OP_SW = 6'b101011;

   // Bit of the EX control byte that enables the register-file write.
   localparam int CTRL_REGWRITE = 7;

   // Request FSM: IDLE accepts instructions, ACCESS waits for the memory.
   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   // True for the opcodes that need a data-memory access.
   function automatic logic is_mem_op(input logic [5:0] opcode);
      return (opcode == OP_LW) || (opcode == OP_SW);
   endfunction

endpackage

// File: rtl/mem_req_fsm.sv
// Request sequencer for the MEM stage: holds the IDLE/ACCESS state and the
// timeout counter, decodes mem_req/stall from the state register and flags
// how an access finished (acknowledged or timed out).
module mem_req_fsm
   import mips_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic   clock,
   input  logic   reset,
   input  logic   start,        // aligned lw/sw accepted this cycle
   input  logic   mem_ack,
   output state_t state,
   output logic   stall,
   output logic   mem_req,
   output logic   done_ack,     // access completes on this edge by ack
   output logic   done_timeout  // access completes on this edge by timeout
);

   // Last ACCESS cycle index before the access is declared a bus error.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           next_state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;

   // State and timeout counter registers; reset abandons any access at once.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         // NOTE: non-blocking (<=) so every flop samples pre-edge values and
         // the order of statements inside the block cannot change behaviour.
         state <= next_state;
         cnt   <= cnt_next;
      end
   end

   // Next-state, counter update and completion flags.
   always_comb begin
      // NOTE: every output gets a default first, so no path leaves a signal
      // unassigned and no latch is inferred.
      next_state   = state;
      cnt_next     = cnt;
      done_ack     = 1'b0;
      done_timeout = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = ACCESS;
               cnt_next   = '0;
            end
         end
         ACCESS: begin
            // An ack on the final cycle still wins over the timeout.
            if (mem_ack) begin
               done_ack   = 1'b1;
               next_state = IDLE;
               cnt_next   = '0;
            end else if (cnt == CNT_LAST) begin
               done_timeout = 1'b1;
               next_state   = IDLE;
               cnt_next     = '0;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         default: begin
            next_state = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Request and upstream stall are both a pure decode of the state register.
   assign mem_req = (state == ACCESS);
   assign stall   = (state == ACCESS);

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: passes ALU results to writeback with one cycle of
// latency and performs lw/sw over a req/ack data-memory port, stalling the
// upstream stage while an access is outstanding.
module mem_access_stage
   import mips_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [31:0] in_d1,
   input  logic [31:0] in_d2,
   input  logic [7:0]  in_control,
   input  logic [5:0]  in_opcode,
   input  logic [4:0]  in_dest,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        wb_valid,
   output logic [31:0] wb_data,
   output logic [4:0]  wb_dest,
   output logic        wb_reg_write,
   output logic        align_err,
   output logic        bus_err
);

   state_t     state;
   logic       accept;
   logic       is_mem;
   logic       aligned;
   logic       start;
   logic       done_ack;
   logic       done_timeout;
   logic [4:0] cap_dest;
   logic       cap_reg_write;
   logic       unused_ctrl;

   // Only the register-write bit of the control byte matters here.
   assign unused_ctrl = ^in_control[6:0];

   // Instructions are accepted only in IDLE; in_* are ignored during ACCESS.
   assign accept  = (state == IDLE) && in_valid;
   assign is_mem  = is_mem_op(in_opcode);
   assign aligned = (in_d1[1:0] == 2'b00);
   assign start   = accept && is_mem && aligned;

   mem_req_fsm #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_fsm (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .mem_ack      (mem_ack),
      .state        (state),
      .stall        (stall),
      .mem_req      (mem_req),
      .done_ack     (done_ack),
      .done_timeout (done_timeout)
   );

   // Capture the access at issue; these hold steady for the whole ACCESS interval.
   always_ff @(posedge clock or posedge reset) begin
      // NOTE: these datapath registers are reset because the memory port must
      // read all-zero from reset; no storage array is involved.
      if (reset) begin
         mem_addr      <= '0;
         mem_wdata     <= '0;
         mem_we        <= 1'b0;
         cap_dest      <= '0;
         cap_reg_write <= 1'b0;
      end else if (start) begin
         mem_addr      <= in_d1;
         mem_wdata     <= in_d2;
         mem_we        <= (in_opcode == OP_SW);
         cap_dest      <= in_dest;
         cap_reg_write <= in_control[CTRL_REGWRITE];
      end
   end

   // MEM/WB register: pulses clear every cycle, payload holds unless a result lands.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wb_valid     <= 1'b0;
         wb_data      <= '0;
         wb_dest      <= '0;
         wb_reg_write <= 1'b0;
         align_err    <= 1'b0;
         bus_err      <= 1'b0;
      end else begin
         wb_valid  <= 1'b0;
         align_err <= 1'b0;
         bus_err   <= 1'b0;
         if (accept && !is_mem) begin
            wb_valid     <= 1'b1;
            wb_data      <= in_d2;
            wb_dest      <= in_dest;
            wb_reg_write <= in_control[CTRL_REGWRITE];
         end else if (accept && !aligned) begin
            // Misaligned lw/sw never reaches the bus; report and drop it.
            wb_valid     <= 1'b1;
            align_err    <= 1'b1;
            wb_data      <= '0;
            wb_dest      <= in_dest;
            wb_reg_write <= 1'b0;
         end else if (done_ack) begin
            wb_valid     <= 1'b1;
            wb_dest      <= cap_dest;
            wb_data      <= mem_we ? 32'h0 : mem_rdata;
            wb_reg_write <= mem_we ? 1'b0 : cap_reg_write;
         end else if (done_timeout) begin
            wb_valid     <= 1'b1;
            bus_err      <= 1'b1;
            wb_dest      <= cap_dest;
            wb_data      <= '0;
            wb_reg_write <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage against a
// transaction-level model of the stage's writeback results.
module tb_mem_access_stage;

   localparam int         TIMEOUT = 16;
   localparam logic [5:0] LW_OPC  = 6'b100011;
   localparam logic [5:0] SW_OPC  = 6'b101011;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic [31:0] in_d1;
   logic [31:0] in_d2;
   logic [7:0]  in_control;
   logic [5:0]  in_opcode;
   logic [4:0]  in_dest;
   logic        stall;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        wb_valid;
   logic [31:0] wb_data;
   logic [4:0]  wb_dest;
   logic        wb_reg_write;
   logic        align_err;
   logic        bus_err;

   mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
      .clock        (clock),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_d1        (in_d1),
      .in_d2        (in_d2),
      .in_control   (in_control),
      .in_opcode    (in_opcode),
      .in_dest      (in_dest),
      .stall        (stall),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_ack      (mem_ack),
      .wb_valid     (wb_valid),
      .wb_data      (wb_data),
      .wb_dest      (wb_dest),
      .wb_reg_write (wb_reg_write),
      .align_err    (align_err),
      .bus_err      (bus_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_pass  = 0;
   int n_total = 0;

   // Model of the writeback payload that must hold between results.
   logic [31:0] m_data = '0;
   logic        m_rw   = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   typedef struct {
      int          req_cycles;
      logic        align;
      logic        bus;
      logic [31:0] data;
      logic        rw;
      logic [4:0]  dest;
   } exp_t;

   // Outcome of one instruction, derived from the stage's rules:
   // k = ACCESS cycle on which the memory acks (k > TIMEOUT: never).
   function automatic exp_t predict(input logic [5:0] opc, input logic [31:0] d1,
                                    input logic [31:0] d2, input logic [7:0] ctrl,
                                    input logic [4:0] dest, input int k,
                                    input logic [31:0] rdata);
      exp_t e;
      e.req_cycles = 0;
      e.align      = 1'b0;
      e.bus        = 1'b0;
      e.dest       = dest;
      if (opc != LW_OPC && opc != SW_OPC) begin
         e.data = d2;
         e.rw   = ctrl[7];
      end else if (d1 % 4 != 0) begin
         e.align = 1'b1;
         e.data  = 32'h0;
         e.rw    = 1'b0;
      end else if (k <= TIMEOUT) begin
         e.req_cycles = k;
         e.data       = (opc == LW_OPC) ? rdata : 32'h0;
         e.rw         = (opc == LW_OPC) ? ctrl[7] : 1'b0;
      end else begin
         e.req_cycles = TIMEOUT;
         e.bus        = 1'b1;
         e.data       = 32'h0;
         e.rw         = 1'b0;
      end
      return e;
   endfunction

   // Issue one instruction from IDLE and follow it to its writeback pulse.
   task automatic issue(input logic [5:0] opc, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [7:0] ctrl, input logic [4:0] dest, input int k,
                        input logic [31:0] rdata);
      exp_t e;
      e = predict(opc, d1, d2, ctrl, dest, k, rdata);
      @(negedge clock);
      check("idle_stall", 32'(stall), 32'(1'b0));
      check("idle_wb_valid", 32'(wb_valid), 32'(1'b0));
      check("hold_wb_data", wb_data, m_data);
      check("hold_wb_reg_write", 32'(wb_reg_write), 32'(m_rw));
      in_valid   = 1'b1;
      in_opcode  = opc;
      in_d1      = d1;
      in_d2      = d2;
      in_control = ctrl;
      in_dest    = dest;
      @(negedge clock);
      for (int c = 1; c <= e.req_cycles; c++) begin
         check("acc_mem_req", 32'(mem_req), 32'(1'b1));
         check("acc_stall", 32'(stall), 32'(1'b1));
         check("acc_mem_addr", mem_addr, d1);
         check("acc_mem_wdata", mem_wdata, d2);
         check("acc_mem_we", 32'(mem_we), 32'(opc == SW_OPC));
         check("acc_wb_valid", 32'(wb_valid), 32'(1'b0));
         // Garbage on the inputs during ACCESS must be ignored.
         in_valid   = 1'($urandom);
         in_opcode  = 6'($urandom);
         in_d1      = $urandom;
         in_d2      = $urandom;
         in_control = 8'($urandom);
         in_dest    = 5'($urandom);
         mem_ack    = (c == k);
         mem_rdata  = (c == k) ? rdata : $urandom;
         @(negedge clock);
      end
      in_valid = 1'b0;
      mem_ack  = 1'b0;
      check("wb_valid", 32'(wb_valid), 32'(1'b1));
      check("wb_data", wb_data, e.data);
      check("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
      check("align_err", 32'(align_err), 32'(e.align));
      check("bus_err", 32'(bus_err), 32'(e.bus));
      check("done_stall", 32'(stall), 32'(1'b0));
      check("done_mem_req", 32'(mem_req), 32'(1'b0));
      if (!e.align) check("wb_dest", 32'(wb_dest), 32'(e.dest));
      m_data = e.data;
      m_rw   = e.rw;
   endtask

   initial begin
      reset      = 1'b1;
      in_valid   = 1'b0;
      in_d1      = '0;
      in_d2      = '0;
      in_control = '0;
      in_opcode  = '0;
      in_dest    = '0;
      mem_rdata  = '0;
      mem_ack    = 1'b0;
      repeat (2) @(negedge clock);
      check("rst_stall", 32'(stall), 32'(1'b0));
      check("rst_mem_req", 32'(mem_req), 32'(1'b0));
      check("rst_mem_we", 32'(mem_we), 32'(1'b0));
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wdata", mem_wdata, 32'h0);
      check("rst_wb_valid", 32'(wb_valid), 32'(1'b0));
      check("rst_wb_data", wb_data, 32'h0);
      check("rst_wb_dest", 32'(wb_dest), 32'h0);
      check("rst_wb_reg_write", 32'(wb_reg_write), 32'(1'b0));
      check("rst_align_err", 32'(align_err), 32'(1'b0));
      check("rst_bus_err", 32'(bus_err), 32'(1'b0));
      reset = 1'b0;

      // Directed cases.
      issue(6'd0, 32'h0, 32'h0000_0007, 8'h80, 5'd3, 0, 32'h0);          // add
      issue(LW_OPC, 32'h100, 32'h0, 8'h80, 5'd9, 3, 32'hDEAD_BEEF);     // lw, ack 3rd cycle
      issue(SW_OPC, 32'h40, 32'h1234, 8'h00, 5'd4, 2, 32'h5555_5555);   // sw
      issue(LW_OPC, 32'h102, 32'h0, 8'h80, 5'd5, 1, 32'h0);             // misaligned lw
      issue(SW_OPC, 32'h80, 32'hABCD, 8'h80, 5'd6, TIMEOUT, 32'h0);     // ack on last cycle
      issue(LW_OPC, 32'h200, 32'h0, 8'h80, 5'd7, TIMEOUT + 5, 32'h0);   // timeout

      // Late ack two cycles after the timeout result: no effect.
      @(negedge clock);
      mem_ack   = 1'b1;
      mem_rdata = 32'hFFFF_FFFF;
      @(negedge clock);
      mem_ack = 1'b0;
      check("late_ack_wb_valid", 32'(wb_valid), 32'(1'b0));
      check("late_ack_mem_req", 32'(mem_req), 32'(1'b0));
      check("late_ack_stall", 32'(stall), 32'(1'b0));

      // Reset in the second ACCESS cycle of a lw.
      @(negedge clock);
      in_valid  = 1'b1;
      in_opcode = LW_OPC;
      in_d1     = 32'h300;
      in_d2     = 32'h0;
      in_control = 8'h80;
      in_dest   = 5'd8;
      @(negedge clock);
      in_valid = 1'b0;
      check("rma_req_c1", 32'(mem_req), 32'(1'b1));
      @(negedge clock);
      check("rma_req_c2", 32'(mem_req), 32'(1'b1));
      #2 reset = 1'b1;
      #1;
      check("rma_mem_req", 32'(mem_req), 32'(1'b0));
      check("rma_stall", 32'(stall), 32'(1'b0));
      check("rma_wb_valid", 32'(wb_valid), 32'(1'b0));
      check("rma_mem_addr", mem_addr, 32'h0);
      @(negedge clock);
      reset   = 1'b0;
      mem_ack = 1'b1;
      m_data  = '0;
      m_rw    = 1'b0;
      @(negedge clock);
      mem_ack = 1'b0;
      check("rma_late_ack_wb_valid", 32'(wb_valid), 32'(1'b0));
      check("rma_late_ack_req", 32'(mem_req), 32'(1'b0));
      issue(6'd0, 32'h0, 32'h0000_0055, 8'h80, 5'd12, 0, 32'h0);

      // Randomized instruction mix.
      for (int n = 0; n < 80; n++) begin
         logic [5:0]  opc;
         logic [31:0] d1;
         int          sel;
         sel = $urandom_range(0, 3);
         case (sel)
            1:       opc = LW_OPC;
            2:       opc = SW_OPC;
            default: opc = 6'($urandom);
         endcase
         d1 = $urandom;
         if ($urandom_range(0, 3) != 0) d1[1:0] = 2'b00;
         issue(opc, d1, $urandom, 8'($urandom), 5'($urandom),
               $urandom_range(1, TIMEOUT + 2), $urandom);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
